// File: rtl/clock_div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clock_div_ctrl_pkg
// Shared types and constants for the divider-ratio controller.
//   state_t      : controller FSM states
//   DIV_W        : width of a divide ratio
//   RESET_STATE  : state entered on reset
//   max_int()    : helper used to size the shared down-counter
// -----------------------------------------------------------------------------
package clock_div_ctrl_pkg;

  localparam int DIV_W = 8;

  typedef enum logic [2:0] {
    BOOT_SETTLE = 3'd0,
    IDLE        = 3'd1,
    GATE        = 3'd2,
    UPDATE      = 3'd3,
    SETTLE      = 3'd4,
    UNGATE      = 3'd5
  } state_t;

  localparam state_t RESET_STATE = BOOT_SETTLE;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clock_div_rr_arb.sv
// -----------------------------------------------------------------------------
// clock_div_rr_arb
// Purely combinational round-robin picker: grants the first valid requester
// at or after the pointer, wrapping around. Nothing is granted while en=0.
// Ports:
//   valid [NUM_REQ-1:0] in  - request valid vector
//   ptr   [ID_W-1:0]    in  - index with highest priority this cycle
//   en                  in  - arbitration enable
//   grant [NUM_REQ-1:0] out - one-hot grant (or zero)
//   index [ID_W-1:0]    out - binary index of the granted requester
// -----------------------------------------------------------------------------
module clock_div_rr_arb #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    index
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // Candidate index rotated by the pointer; the pointer is always < NUM_REQ,
      // so a single subtraction handles the wrap.
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (en && !found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/clock_div_ctrl.sv
// -----------------------------------------------------------------------------
// clock_div_ctrl
// Owns the ratio input of one clock divider and the clock-enable of the domain
// it feeds. Ratio-change requests are arbitrated round-robin and each change is
// sequenced gate -> update -> settle -> ungate.
// Optional feature: define CLOCK_DIV_CTRL_CNT_EN to add io_change_cnt, a
// saturating count of completed ratio changes (io_done pulses).
// Ports:
//   clock          in  - reference clock (same as the divider's reference)
//   reset          in  - asynchronous, active-high
//   io_req_valid   in  - per-requester valid
//   io_req_div     in  - requested ratios, requester i at [8i+7:8i]
//   io_req_ready   out - per-requester ready, one-hot or zero, IDLE only
//   io_div         out - registered ratio to the divider
//   io_clk_en      out - registered enable for the divided domain
//   io_done        out - one-cycle pulse, ratio change complete
//   io_err         out - one-cycle pulse, request with ratio 0 rejected
//   io_grant_id    out - index of the last accepted requester
//   io_change_cnt  out - (CLOCK_DIV_CTRL_CNT_EN only) completed changes
// -----------------------------------------------------------------------------
module clock_div_ctrl
  import clock_div_ctrl_pkg::*;
#(
  parameter  int           NUM_REQ       = 2,
  parameter  logic [7:0]   DIV_RESET     = 8'h2,
  parameter  int           GATE_CYCLES   = 2,
  parameter  int           SETTLE_CYCLES = 4,
  localparam int           ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       io_req_valid,
  input  logic [NUM_REQ*DIV_W-1:0] io_req_div,
  output logic [NUM_REQ-1:0]       io_req_ready,
  output logic [DIV_W-1:0]         io_div,
  output logic                     io_clk_en,
  output logic                     io_done,
  output logic                     io_err,
  output logic [ID_W-1:0]          io_grant_id
`ifdef CLOCK_DIV_CTRL_CNT_EN
  ,
  output logic [15:0]              io_change_cnt
`endif
);

  localparam int CNT_W = $clog2(max_int(GATE_CYCLES, SETTLE_CYCLES) + 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [ID_W-1:0]    ptr_reg, ptr_next;
  logic [DIV_W-1:0]   target_reg, target_next;
  logic [DIV_W-1:0]   div_next;
  logic               clk_en_next;
  logic               done_next;
  logic               err_next;
  logic [ID_W-1:0]    grant_id_next;

  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0]    arb_idx;
  logic               xfer;
  logic [DIV_W-1:0]   sel_ratio;
  logic [DIV_W-1:0]   req_ratio [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_ratio[gi] = io_req_div[gi*DIV_W +: DIV_W];
    end
  endgenerate

  clock_div_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .valid (io_req_valid),
    .ptr   (ptr_reg),
    .en    (state_reg == IDLE),
    .grant (arb_grant),
    .index (arb_idx)
  );

  // The arbiter only grants valid requesters, so any grant is a transfer.
  assign io_req_ready = arb_grant;
  assign xfer         = |arb_grant;
  assign sel_ratio    = req_ratio[arb_idx];

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    ptr_next      = ptr_reg;
    target_next   = target_reg;
    div_next      = io_div;
    clk_en_next   = io_clk_en;
    done_next     = 1'b0;
    err_next      = 1'b0;
    grant_id_next = io_grant_id;

    case (state_reg)
      BOOT_SETTLE: begin
        // Ungate after boot without a done pulse.
        if (cnt_reg == '0) begin
          state_next  = UNGATE;
          clk_en_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      IDLE: begin
        if (xfer) begin
          grant_id_next = arb_idx;
          ptr_next      = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          if (sel_ratio == '0) begin
            err_next = 1'b1;
          end else if (sel_ratio == io_div) begin
            done_next = 1'b1;
          end else begin
            target_next = sel_ratio;
            state_next  = GATE;
            cnt_next    = CNT_W'(GATE_CYCLES - 1);
            clk_en_next = 1'b0;
          end
        end
      end

      GATE: begin
        if (cnt_reg == '0) begin
          state_next = UPDATE;
          div_next   = target_reg;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      UPDATE: begin
        state_next = SETTLE;
        cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
      end

      SETTLE: begin
        if (cnt_reg == '0) begin
          state_next  = UNGATE;
          clk_en_next = 1'b1;
          done_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      UNGATE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = RESET_STATE;
      end
    endcase
  end

  // Outputs are registered from their next values so that a state and its
  // visible effect (gating, new ratio, done) appear in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= RESET_STATE;
      cnt_reg     <= CNT_W'(SETTLE_CYCLES);
      ptr_reg     <= '0;
      target_reg  <= DIV_RESET;
      io_div      <= DIV_RESET;
      io_clk_en   <= 1'b0;
      io_done     <= 1'b0;
      io_err      <= 1'b0;
      io_grant_id <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ptr_reg     <= ptr_next;
      target_reg  <= target_next;
      io_div      <= div_next;
      io_clk_en   <= clk_en_next;
      io_done     <= done_next;
      io_err      <= err_next;
      io_grant_id <= grant_id_next;
    end
  end

`ifdef CLOCK_DIV_CTRL_CNT_EN
  // Updates on the same edge that raises io_done, saturating at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_change_cnt <= '0;
    end else if (done_next && (io_change_cnt != 16'hFFFF)) begin
      io_change_cnt <= io_change_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clock_div_ctrl.sv
module tb_clock_div_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_div = 16'h0000;
  logic [1:0]  io_req_ready;
  logic [7:0]  io_div;
  logic        io_clk_en;
  logic        io_done;
  logic        io_err;
  logic [0:0]  io_grant_id;
`ifdef CLOCK_DIV_CTRL_CNT_EN
  logic [15:0] io_change_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  clock_div_ctrl #(
    .NUM_REQ       (2),
    .DIV_RESET     (8'h2),
    .GATE_CYCLES   (2),
    .SETTLE_CYCLES (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_req_valid (req_valid),
    .io_req_div   (req_div),
    .io_req_ready (io_req_ready),
    .io_div       (io_div),
    .io_clk_en    (io_clk_en),
    .io_done      (io_done),
    .io_err       (io_err),
    .io_grant_id  (io_grant_id)
`ifdef CLOCK_DIV_CTRL_CNT_EN
    ,
    .io_change_cnt (io_change_cnt)
`endif
  );

  always #5 clock = ~clock;

  // Reset held for two cycles, then the boot sequence: clk_en low for
  // cycles 1..4 after deassert, high from cycle 5, never a done pulse.
  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    @(negedge clock);
    @(negedge clock);
    compared++;
    if ({io_div, io_clk_en, io_req_ready, io_done, io_err, io_grant_id} !== {8'h02, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL reset_values: got div=%h en=%b rdy=%b done=%b err=%b id=%b, expected div=02 en=0 rdy=00 done=0 err=0 id=0",
               io_div, io_clk_en, io_req_ready, io_done, io_err, io_grant_id);
    end
`ifdef CLOCK_DIV_CTRL_CNT_EN
    compared++;
    if (io_change_cnt !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_cnt: got %0d expected 0", io_change_cnt);
    end
`endif
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      compared++;
      if ({io_clk_en, io_done, io_div} !== {(k >= 5), 1'b0, 8'h02}) begin
        mismatched++;
        $display("FAIL boot_cycle%0d: got en=%b done=%b div=%h expected en=%b done=0 div=02",
                 k, io_clk_en, io_done, io_div, (k >= 5));
      end
    end
    $display("reset/boot sequence checked");
  endtask

  // Req0 ratio 4 from 2: gate at T+1, new ratio at T+3, done + ungate at T+8.
  task automatic test_change();
    req_div   = {8'd0, 8'd4};
    req_valid = 2'b01;
    #1;
    compared++;
    if (io_req_ready !== 2'b01) begin
      mismatched++;
      $display("FAIL change_ready: got %b expected 01", io_req_ready);
    end
    @(posedge clock);
    #1 req_valid = 2'b00;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      compared++;
      if ({io_clk_en, io_div, io_done, io_err} !== {(k >= 8), ((k >= 3) ? 8'd4 : 8'd2), (k == 8), 1'b0}) begin
        mismatched++;
        $display("FAIL change_T+%0d: got en=%b div=%0d done=%b err=%b expected en=%b div=%0d done=%b err=0",
                 k, io_clk_en, io_div, io_done, io_err, (k >= 8), ((k >= 3) ? 8'd4 : 8'd2), (k == 8));
      end
    end
    compared++;
    if (io_grant_id !== 1'b0) begin
      mismatched++;
      $display("FAIL change_grant_id: got %b expected 0", io_grant_id);
    end
    $display("req0 change 2->4 checked");
  endtask

  // Req1 ratio 0 -> err at T+1; then req0 ratio equal to current -> done at T+1.
  task automatic test_zero_same();
    req_div   = {8'd0, 8'd4};
    req_valid = 2'b10;
    #1;
    compared++;
    if (io_req_ready !== 2'b10) begin
      mismatched++;
      $display("FAIL zero_ready: got %b expected 10", io_req_ready);
    end
    @(posedge clock);
    #1 req_valid = 2'b00;
    @(negedge clock);
    compared++;
    if ({io_err, io_done, io_div, io_clk_en, io_grant_id} !== {1'b1, 1'b0, 8'd4, 1'b1, 1'b1}) begin
      mismatched++;
      $display("FAIL zero_resp: got err=%b done=%b div=%0d en=%b id=%b expected err=1 done=0 div=4 en=1 id=1",
               io_err, io_done, io_div, io_clk_en, io_grant_id);
    end
    // Ready must already be available in T+1.
    req_valid = 2'b01;
    #1;
    compared++;
    if (io_req_ready !== 2'b01) begin
      mismatched++;
      $display("FAIL same_ready: got %b expected 01", io_req_ready);
    end
    @(posedge clock);
    #1 req_valid = 2'b00;
    @(negedge clock);
    compared++;
    if ({io_done, io_err, io_div, io_clk_en, io_grant_id} !== {1'b1, 1'b0, 8'd4, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL same_resp: got done=%b err=%b div=%0d en=%b id=%b expected done=1 err=0 div=4 en=1 id=0",
               io_done, io_err, io_div, io_clk_en, io_grant_id);
    end
    @(negedge clock);
    compared++;
    if ({io_done, io_err, io_clk_en} !== {1'b0, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL same_after: got done=%b err=%b en=%b expected done=0 err=0 en=1",
               io_done, io_err, io_clk_en);
    end
`ifdef CLOCK_DIV_CTRL_CNT_EN
    compared++;
    if (io_change_cnt !== 16'd2) begin
      mismatched++;
      $display("FAIL cnt_after_same: got %0d expected 2", io_change_cnt);
    end
`endif
    $display("zero and same-ratio requests checked");
  endtask

  // Req1 ratio 8 (pointer is 1); reset asserted in SETTLE.
  task automatic test_reset_mid();
    req_div   = {8'd8, 8'd0};
    req_valid = 2'b10;
    @(posedge clock);
    #1 req_valid = 2'b00;
    repeat (5) @(negedge clock);
    compared++;
    if ({io_div, io_clk_en} !== {8'd8, 1'b0}) begin
      mismatched++;
      $display("FAIL mid_settle: got div=%0d en=%b expected div=8 en=0", io_div, io_clk_en);
    end
    reset = 1'b1;
    #1;
    compared++;
    if ({io_div, io_clk_en, io_grant_id, io_done} !== {8'd2, 1'b0, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL mid_reset_now: got div=%0d en=%b id=%b done=%b expected div=2 en=0 id=0 done=0",
               io_div, io_clk_en, io_grant_id, io_done);
    end
    test_reset();
    @(negedge clock);
    compared++;
    if ({io_done, io_div, io_clk_en} !== {1'b0, 8'd2, 1'b1}) begin
      mismatched++;
      $display("FAIL mid_lost_req: got done=%b div=%0d en=%b expected done=0 div=2 en=1",
               io_done, io_div, io_clk_en);
    end
    $display("reset during settle checked");
  endtask

  // Round-robin: two simultaneous pairs, each served req0 then req1.
  task automatic test_rr();
    logic [1:0]  vb [4] = '{2'b11, 2'b10, 2'b11, 2'b10};
    logic [1:0]  va [4] = '{2'b10, 2'b00, 2'b10, 2'b00};
    logic [1:0]  rd [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [15:0] dv [4] = '{{8'd8, 8'd4}, {8'd8, 8'd4}, {8'd8, 8'd2}, {8'd8, 8'd2}};
    logic [7:0]  od [4] = '{8'd2, 8'd4, 8'd8, 8'd2};
    logic [7:0]  nd [4] = '{8'd4, 8'd8, 8'd2, 8'd8};
    logic [0:0]  id [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int s = 0; s < 4; s++) begin
      req_div   = dv[s];
      req_valid = vb[s];
      #1;
      compared++;
      if (io_req_ready !== rd[s]) begin
        mismatched++;
        $display("FAIL rr%0d_ready: got %b expected %b", s, io_req_ready, rd[s]);
      end
      @(posedge clock);
      #1 req_valid = va[s];
      for (int k = 1; k <= 9; k++) begin
        @(negedge clock);
        compared++;
        if ({io_clk_en, io_div, io_done, io_req_ready} !==
            {(k >= 8), ((k >= 3) ? nd[s] : od[s]), (k == 8), ((k == 9) ? va[s] : 2'b00)}) begin
          mismatched++;
          $display("FAIL rr%0d_T+%0d: got en=%b div=%0d done=%b rdy=%b expected en=%b div=%0d done=%b rdy=%b",
                   s, k, io_clk_en, io_div, io_done, io_req_ready,
                   (k >= 8), ((k >= 3) ? nd[s] : od[s]), (k == 8), ((k == 9) ? va[s] : 2'b00));
        end
        if (k == 1) begin
          compared++;
          if (io_grant_id !== id[s]) begin
            mismatched++;
            $display("FAIL rr%0d_grant_id: got %b expected %b", s, io_grant_id, id[s]);
          end
        end
      end
      $display("rr step %0d: requester %0d ratio %0d->%0d checked", s, id[s], od[s], nd[s]);
    end
`ifdef CLOCK_DIV_CTRL_CNT_EN
    compared++;
    if (io_change_cnt !== 16'd4) begin
      mismatched++;
      $display("FAIL cnt_after_rr: got %0d expected 4", io_change_cnt);
    end
`endif
  endtask

  // Three changes plus one zero request from a fresh reset.
  task automatic test_cnt();
`ifdef CLOCK_DIV_CTRL_CNT_EN
    logic [7:0] ratios [4] = '{8'd5, 8'd0, 8'd6, 8'd7};
    test_reset();
    for (int s = 0; s < 4; s++) begin
      req_div   = {ratios[s], ratios[s]};
      req_valid = 2'b01;
      @(posedge clock);
      #1 req_valid = 2'b00;
      repeat (9) @(negedge clock);
    end
    compared++;
    if (io_change_cnt !== 16'd3) begin
      mismatched++;
      $display("FAIL cnt_three_changes: got %0d expected 3", io_change_cnt);
    end
    $display("change counter checked");
`endif
  endtask

  initial begin
    test_reset();
    test_change();
    test_zero_same();
    test_reset_mid();
    test_rr();
    test_cnt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/clock_div_ctrl.md
# clock_div_ctrl

Synthesizable controller that owns the `io_div` input of one clock divider and the clock-enable of the logic that divider feeds. It arbitrates divide-ratio change requests from `NUM_REQ` requesters (round-robin) and sequences each change safely: gate, update ratio, settle, ungate. It sits in the top-level clock fabric beside each divider instance, replacing hard-wired ratio constants.

## Interface
- `NUM_REQ`, 2 — number of requesters (≥1)
- `DIV_RESET`, 8'h2 — ratio driven from reset
- `GATE_CYCLES`, 2 — cycles clock stays gated before the ratio update (≥1)
- `SETTLE_CYCLES`, 4 — cycles held gated after the ratio update (≥1)

Ports:
- `clock` in 1 — reference clock (same clock feeding the divider's `io_clock_ref`)
- `reset` in 1 — asynchronous, active-high
- `io_req_valid` in NUM_REQ — per-requester request valid
- `io_req_div` in NUM_REQ*8 — requested ratios; requester i at bits [8i+7:8i]
- `io_req_ready` out NUM_REQ — per-requester ready, one-hot or zero
- `io_div` out 8 — ratio to divider, registered
- `io_clk_en` out 1 — enable for the divided domain, registered
- `io_done` out 1 — one-cycle pulse, ratio change complete
- `io_err` out 1 — one-cycle pulse, request rejected (ratio 0)
- `io_grant_id` out $clog2(NUM_REQ) (min 1) — index of last accepted requester

## Operation
- States: BOOT_SETTLE, IDLE, GATE, UPDATE, SETTLE, UNGATE.
- Reset values: `io_div`=DIV_RESET, `io_clk_en`=0, `io_req_ready`=0, `io_done`=0, `io_err`=0, `io_grant_id`=0, RR pointer=0, state=BOOT_SETTLE, counter=SETTLE_CYCLES.
- BOOT_SETTLE: held SETTLE_CYCLES cycles, then UNGATE. No `io_done` pulse on the boot UNGATE.
- IDLE: the arbiter picks the first valid requester at or after the RR pointer (wrapping). Only that requester's `io_req_ready` is high, combinationally, in IDLE only. Transfer = valid & ready in the same cycle. Requesters hold valid and data stable until transfer.
- On transfer: latch ratio and id. Advance the pointer to (id+1) mod NUM_REQ.
  - Ratio 0: pulse `io_err` next cycle and stay in IDLE. No gating; `io_div` is unchanged.
  - Ratio equal to current `io_div`: pulse `io_done` next cycle and stay in IDLE. No gating.
  - Otherwise go to GATE.
- GATE: `io_clk_en`=0 for GATE_CYCLES cycles, then UPDATE.
- UPDATE: one cycle; `io_div` takes the new ratio in this cycle.
- SETTLE: SETTLE_CYCLES cycles with `io_clk_en`=0.
- UNGATE: one cycle. `io_clk_en`=1 from this cycle on, `io_done`=1 in this cycle only, then IDLE.
- Ratio is 8-bit unsigned with no arithmetic. The counter is a down-counter of width $clog2(max(GATE_CYCLES,SETTLE_CYCLES)+1).
- Valid deasserted before transfer: the request is withdrawn with no effect.
- Reset mid-sequence: immediate return to reset values and BOOT_SETTLE. The in-flight request is lost and not re-queued.

## Timing
- Transfer at cycle T with a new, nonzero ratio (G=GATE_CYCLES, S=SETTLE_CYCLES):
  - GATE occupies T+1..T+G; `io_clk_en` falls at T+1.
  - UPDATE is at T+G+1.
  - SETTLE occupies T+G+2..T+G+S+1.
  - UNGATE/`io_done` is at T+G+S+2.
  - Next `io_req_ready` is possible at T+G+S+3.
- Same-ratio or zero-ratio request: response pulse at T+1; next ready possible at T+1.
- After reset deassert: `io_clk_en` rises in cycle S+1, counting the first clock edge after deassert as cycle 1.

## Configuration
- `CLOCK_DIV_CTRL_CNT_EN` defined: adds output `io_change_cnt` [15:0]. It resets to 0, increments on each `io_done`, and saturates at 16'hFFFF. `io_err` and boot do not count.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package `clock_div_ctrl_pkg`: state enum typedef, `DIV_W`=8, reset-state constant.
- Sub-module `clock_div_rr_arb`:
  - Parameterized by NUM_REQ.
  - Inputs: valid vector, pointer, enable.
  - Outputs: one-hot grant and binary index.
- The FSM, counter and output registers live in `clock_div_ctrl`.

## Test plan
- Reset, then idle (S=4): `io_div`=2, `io_clk_en`=0 for 4 cycles, 1 from cycle 5; no `io_done`.
- Req0 ratio 4 at T (G=2,S=4): `io_clk_en`=0 at T+1, `io_div`=4 at T+3, `io_done` and `io_clk_en`=1 at T+8.
- Req0 and req1 valid together, ratios 4 and 8: req0 granted first, `io_grant_id`=0. Req1 is granted at the next IDLE and final `io_div`=8. A second simultaneous pair starts with req0 again because the pointer wrapped.
- Req1 ratio 0: `io_err` at T+1, `io_div` unchanged, `io_clk_en` stays 1. Ratio equal to current: `io_done` at T+1, no gating.
- Assert reset during SETTLE of a change to 8: `io_div`=2 and `io_clk_en`=0 immediately; after deassert the boot sequence reruns and no `io_done` is produced for the lost request.
- With `CLOCK_DIV_CTRL_CNT_EN`: three valid changes plus one zero request give `io_change_cnt`=3.
